// File: rtl/pooling_layer.sv
// 2x2 stride-2 pooling (average or max) over a stack of square feature maps in
// word-wide memory; one read or write per cycle, six cycles per pooled output.
module pooling_layer #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               poolType,
  input  logic [DATA_SZ-1:0] imgsNumber,
  input  logic [DATA_SZ-1:0] imgSize,
  input  logic [ADDR_SZ-1:0] imgsAddress,
  input  logic [ADDR_SZ-1:0] outAddress,
  output logic               readEnable,
  output logic [ADDR_SZ-1:0] readAddr,
  input  logic [DATA_SZ-1:0] readData,
  output logic               writeEnable,
  output logic [ADDR_SZ-1:0] writeAddr,
  output logic [DATA_SZ-1:0] writeOut,
  output logic               done
);

  localparam int ACC_W = DATA_SZ + 2;
  localparam logic [ADDR_SZ-1:0] A_ONE = ADDR_SZ'(1);
  localparam logic [ADDR_SZ-1:0] A_TWO = ADDR_SZ'(2);
  localparam logic [DATA_SZ-1:0] D_ONE = DATA_SZ'(1);
  localparam logic [DATA_SZ-1:0] D_TWO = DATA_SZ'(2);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, LAST, WR, FIN} state_t;
  state_t state;

  logic                      pool_max;
  logic [DATA_SZ-1:0]        num_q, size_q, half_q;
  logic [DATA_SZ-1:0]        map_cnt, row_cnt, col_cnt;
  logic [ADDR_SZ-1:0]        row_base, win_addr, out_ptr;
  logic [ADDR_SZ-1:0]        size_a, row_step, map_step;
  logic                      last_col, last_row, last_map;
  logic signed [ACC_W-1:0]   sum_p0, sum_fin;
  logic signed [DATA_SZ-1:0] max_p0, rd_s, max_fin, result;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_SZ-1:0] v);
    return {{2{v[DATA_SZ-1]}}, v};
  endfunction

  // Arithmetic shift floors toward -inf, so {-1,-2,-3,-4} pools to -3.
  function automatic logic signed [DATA_SZ-1:0] avg_floor(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] q;
    q = s >>> 2;
    return q[DATA_SZ-1:0];
  endfunction

  function automatic logic signed [DATA_SZ-1:0] run_max(input logic signed [DATA_SZ-1:0] cur,
                                                        input logic signed [DATA_SZ-1:0] nxt);
    return (nxt > cur) ? nxt : cur;
  endfunction

  assign rd_s     = readData;
  assign size_a   = ADDR_SZ'(size_q);
  assign row_step = size_a << 1;
  // After the last output row, row_base + 2S lands on the next map unless S is
  // odd, in which case the dropped last row must be skipped as well.
  assign map_step = row_step + (size_q[0] ? size_a : '0);
  assign last_col = (col_cnt == half_q - D_ONE);
  assign last_row = (row_cnt == half_q - D_ONE);
  assign last_map = (map_cnt == num_q - D_ONE);

  assign sum_fin  = sum_p0 + sext(rd_s);
  assign max_fin  = run_max(max_p0, rd_s);
  assign result   = pool_max ? max_fin : avg_floor(sum_fin);

  // Stage p0: window accumulation, datum k arrives one cycle after read k.
  always_ff @(posedge clk) begin
    case (state)
      RD1: begin
        sum_p0 <= sext(rd_s);
        max_p0 <= rd_s;
      end
      RD2, RD3: begin
        sum_p0 <= sum_p0 + sext(rd_s);
        max_p0 <= run_max(max_p0, rd_s);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pool_max    <= 1'b0;
      num_q       <= '0;
      size_q      <= '0;
      half_q      <= '0;
      map_cnt     <= '0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      row_base    <= '0;
      win_addr    <= '0;
      out_ptr     <= '0;
      readEnable  <= 1'b0;
      readAddr    <= '0;
      writeEnable <= 1'b0;
      writeAddr   <= '0;
      writeOut    <= '0;
      done        <= 1'b0;
    end else begin
      readEnable  <= 1'b0;
      writeEnable <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            pool_max <= poolType;
            num_q    <= imgsNumber;
            size_q   <= imgSize;
            half_q   <= imgSize >> 1;
            out_ptr  <= outAddress;
            map_cnt  <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            row_base <= imgsAddress;
            win_addr <= imgsAddress;
            if (imgsNumber != '0 && imgSize >= D_TWO) begin
              state      <= RD0;
              readEnable <= 1'b1;
              readAddr   <= imgsAddress;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RD0: begin
          state      <= RD1;
          readEnable <= 1'b1;
          readAddr   <= win_addr + A_ONE;
        end
        RD1: begin
          state      <= RD2;
          readEnable <= 1'b1;
          readAddr   <= win_addr + size_a;
        end
        RD2: begin
          state      <= RD3;
          readEnable <= 1'b1;
          readAddr   <= win_addr + size_a + A_ONE;
        end
        RD3: state <= LAST;
        LAST: begin
          state       <= WR;
          writeEnable <= 1'b1;
          writeAddr   <= out_ptr;
          writeOut    <= result;
        end
        WR: begin
          out_ptr <= out_ptr + A_ONE;
          if (last_col && last_row && last_map) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state      <= RD0;
            readEnable <= 1'b1;
            if (!last_col) begin
              col_cnt  <= col_cnt + D_ONE;
              win_addr <= win_addr + A_TWO;
              readAddr <= win_addr + A_TWO;
            end else if (!last_row) begin
              col_cnt  <= '0;
              row_cnt  <= row_cnt + D_ONE;
              row_base <= row_base + row_step;
              win_addr <= row_base + row_step;
              readAddr <= row_base + row_step;
            end else begin
              col_cnt  <= '0;
              row_cnt  <= '0;
              map_cnt  <= map_cnt + D_ONE;
              row_base <= row_base + map_step;
              win_addr <= row_base + map_step;
              readAddr <= row_base + map_step;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pooling_layer.md
# pooling_layer

Downstream neighbour of the convolution layer. Reads the feature maps the convolution layer wrote to data memory and applies 2x2, stride-2 pooling to each one, either average or max. Writes the pooled maps back to memory as a contiguous block, ready for the next convolution or fully-connected stage. Memory is accessed one 16-bit word at a time through a read port and a write port, both owned by the memory arbiter.

## Interface
Parameters:
- DATA_SZ, 16, data word width (signed two's complement)
- ADDR_SZ, 16, memory address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  start request, sampled only in IDLE
- poolType  in  1  0 = average, 1 = max; latched at start
- imgsNumber  in  DATA_SZ  number of input maps
- imgSize  in  DATA_SZ  input map side length S (maps are S x S, row-major)
- imgsAddress  in  ADDR_SZ  address of map 0, element (0,0)
- outAddress  in  ADDR_SZ  address of the first pooled output word
- readEnable  out  1  one-cycle memory read request
- readAddr  out  ADDR_SZ  read address, valid while readEnable=1
- readData  in  DATA_SZ  read data, valid exactly 1 cycle after readEnable
- writeEnable  out  1  one-cycle memory write strobe
- writeAddr  out  ADDR_SZ  write address
- writeOut  out  DATA_SZ  pooled value
- done  out  1  one-cycle pulse at job end

## Operation
- Latching: poolType, imgsNumber, imgSize, imgsAddress and outAddress are latched on the start edge. Later input changes are ignored until the next start.
- Geometry: O = S >> 1. For odd S, the last row and column are dropped.
- Map base: map i has base B_i = imgsAddress + i·S·S, computed by an incrementing adder with no multiplier in the loop.
- Output loop order: map i, then output row r, then output column c, as nested counters.
- Window reads, in this order: B_i+2r·S+2c, then +1, then +S, then +S+1.
- Output addresses: outAddress, outAddress+1, … sequentially across all maps. Total outputs N·O·O.
- FSM states:
  - IDLE: waits for enable=1.
  - RD0–RD3: issue read k.
  - LAST: captures the 4th datum.
  - WR: writes the result, then advances the counters.
  - FIN: asserts done.
- Transitions:
  - IDLE→RD0 when enable=1 and imgsNumber≠0 and imgSize≥2.
  - IDLE→FIN when enable=1 and the job is degenerate (imgsNumber=0 or imgSize<2). No reads or writes occur.
  - RD0→RD1→RD2→RD3→LAST→WR.
  - WR→RD0 if outputs remain, else WR→FIN.
  - FIN→IDLE.
- Accumulation, average mode: 18-bit signed sum, sign-extended per datum. Result = sum >>> 2, an arithmetic shift that floors toward −inf. No overflow is possible.
- Accumulation, max mode: signed compare. The first datum initialises the running max; ties keep the earlier value.
- enable: ignored outside IDLE. Deasserting it mid-job does not abort the job.

## Timing
- Reset values (reset=0): immediately and asynchronously, the FSM goes to IDLE and all counters clear. readEnable, writeEnable and done = 0; readAddr, writeAddr and writeOut = 0.
- Reset mid-job abandons the job: no further reads or writes, and no done pulse.
- Read request: with enable sampled high in IDLE at edge E, readEnable=1 with window read 0 in cycle E+1.
- Per-output cadence: each output takes exactly 6 cycles (RD0–RD3, LAST, WR).
  - Output k's reads are in cycles E+1+6k … E+4+6k.
  - Output k's write (writeEnable=1, writeAddr, writeOut) is in cycle E+6+6k.
- Pipelining: no reads and writes are active in the same cycle.
- done: high for exactly one cycle, in the cycle after the last WR. done for a degenerate job is in cycle E+1.
- Back-to-back jobs: the earliest restart is at the edge ending the cycle after done (the FSM is back in IDLE).
- Hold rule: writeAddr and writeOut hold their last values between strobes. readAddr holds between requests.

## Test plan
- 4x4 ramp, average: map values 0..15 at addr 0, outAddress=100, poolType=0.
  - Expect writes 100←2, 101←4, 102←10, 103←12.
  - Writes in cycles E+6, E+12, E+18, E+24; done at E+25.
- Same map, max mode: expect 100←5, 101←7, 102←13, 103←15.
- Sign and extreme values, one 2x2 map:
  - {-1,-2,-3,-4}, average → -3 (floor of -2.5).
  - {32767 ×4}, average → 32767 (no wrap).
  - {-32768,-1,-5,-7}, max → -1.
- Two 5x5 maps at imgsAddress=0 (map 1 base = 25), outAddress=200:
  - Reads never touch row/column 4 of either map.
  - 8 writes to 200..207; map 1's first window reads 25, 26, 30, 31.
- Degenerate jobs:
  - imgsNumber=0 → done at E+1, no strobes.
  - imgSize=1 → same.
- Reset and restart:
  - Pull reset low in cycle E+8 of the 4x4 job → all outputs 0 that cycle, no further strobes, no done.
  - Then restart → full correct result, as in the first scenario.
